// File: rtl/MD_pkg.sv
// Shared molecular-dynamics types: force vectors, neighbour force packets and
// the ring entry format carried between force output ring nodes.
package MD_pkg;

   localparam int FLOAT_WIDTH          = 32;
   localparam int PARTICLE_ID_WIDTH    = 8;
   localparam int GLOBAL_CELL_ID_WIDTH = 3;
   localparam int NB_CID_WIDTH         = 6;
   localparam int GCID_WIDTH           = 3 * GLOBAL_CELL_ID_WIDTH;

   typedef struct packed {
      logic [FLOAT_WIDTH-1:0] x;
      logic [FLOAT_WIDTH-1:0] y;
      logic [FLOAT_WIDTH-1:0] z;
   } float_data_t;

   typedef struct packed {
      float_data_t                  f;
      logic [PARTICLE_ID_WIDTH-1:0] parid;
      logic [NB_CID_WIDTH-1:0]      cid;
   } force_packet_t;

   // What travels on the ring and sits in the local buffer: cid already resolved to gcid.
   typedef struct packed {
      float_data_t                  f;
      logic [PARTICLE_ID_WIDTH-1:0] parid;
      logic [GCID_WIDTH-1:0]        gcid;
   } ring_entry_t;

   localparam int RING_ENTRY_WIDTH = $bits(ring_entry_t);

   // Relative cell code: 00 = -1, 01 = 0, 10 = +1, 11 = 0; wraps modulo 8.
   function automatic logic [GLOBAL_CELL_ID_WIDTH-1:0] axis_step(
      input logic [GLOBAL_CELL_ID_WIDTH-1:0] home,
      input logic [1:0]                      code
   );
      logic [GLOBAL_CELL_ID_WIDTH-1:0] result;
      case (code)
         2'b00:   result = home - GLOBAL_CELL_ID_WIDTH'(1);
         2'b10:   result = home + GLOBAL_CELL_ID_WIDTH'(1);
         default: result = home;
      endcase
      return result;
   endfunction

   function automatic logic [GCID_WIDTH-1:0] local_gcid(
      input logic [NB_CID_WIDTH-1:0] cid,
      input logic [GCID_WIDTH-1:0]   home
   );
      return {axis_step(home[8:6], cid[5:4]),
              axis_step(home[5:3], cid[3:2]),
              axis_step(home[2:0], cid[1:0])};
   endfunction

endpackage

// File: rtl/force_ring_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the oldest entry while
// empty is low. A write when full is dropped unless a pop happens the same cycle.
module force_ring_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             full;
   logic             rd_ok;
   logic             wr_ok;

   assign full    = (count == FULL_COUNT);
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         empty <= (count_next == '0);
      end
   end

   // Storage needs no reset: pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (rst && wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/force_output_ring_node.sv
// Ring node that merges locally produced neighbour forces into the force ring
// and peels off packets addressed to this node's home cell.
module force_output_ring_node
   import MD_pkg::*;
#(
   parameter logic [2:0] GCELL_X    = 3'b000,
   parameter logic [2:0] GCELL_Y    = 3'b000,
   parameter logic [2:0] GCELL_Z    = 3'b000,
   parameter int         FIFO_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  force_packet_t                i_nb_force,
   input  logic                         i_nb_force_valid,
   input  float_data_t                  i_source_nb_force,
   input  logic [PARTICLE_ID_WIDTH-1:0] i_source_nb_parid,
   input  logic [GCID_WIDTH-1:0]        i_source_nb_gcid,
   input  logic                         i_source_nb_valid,
   output float_data_t                  o_dest_nb_force,
   output logic [PARTICLE_ID_WIDTH-1:0] o_dest_nb_parid,
   output logic [GCID_WIDTH-1:0]        o_dest_nb_gcid,
   output logic                         o_dest_nb_valid,
   output float_data_t                  o_nb_force_to_force_cache,
   output logic                         o_nb_force_to_force_cache_valid,
   output logic [PARTICLE_ID_WIDTH-1:0] o_nb_parid_to_force_cache,
   output logic                         o_buffer_empty
);

   // All interfaces are valid-only: data transfers in any cycle its valid is
   // high; there is no ready, so ring input is never stalled.
   localparam logic [GCID_WIDTH-1:0] HOME_GCID = {GCELL_Z, GCELL_Y, GCELL_X};

   ring_entry_t                 local_entry;
   ring_entry_t                 ring_entry;
   ring_entry_t                 head_entry;
   logic [RING_ENTRY_WIDTH-1:0] head_bits;
   logic                        fifo_empty;

   logic ring_home;
   logic ring_transit;
   logic head_home;
   logic head_transit;
   logic pop;

   ring_entry_t dest_sel;
   logic        dest_sel_valid;
   ring_entry_t cache_sel;
   logic        cache_sel_valid;

   always_comb begin
      local_entry       = '0;
      local_entry.f     = i_nb_force.f;
      local_entry.parid = i_nb_force.parid;
      local_entry.gcid  = local_gcid(i_nb_force.cid, HOME_GCID);
   end

   always_comb begin
      ring_entry       = '0;
      ring_entry.f     = i_source_nb_force;
      ring_entry.parid = i_source_nb_parid;
      ring_entry.gcid  = i_source_nb_gcid;
   end

   force_ring_fifo #(
      .WIDTH (RING_ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (i_nb_force_valid),
      .wr_data (local_entry),
      .rd_en   (pop),
      .rd_data (head_bits),
      .empty   (fifo_empty)
   );

   assign head_entry = ring_entry_t'(head_bits);

   // Ring traffic owns each output; the buffer head only fills an idle slot.
   always_comb begin
      ring_home    = i_source_nb_valid && (i_source_nb_gcid == HOME_GCID);
      ring_transit = i_source_nb_valid && (i_source_nb_gcid != HOME_GCID);
      head_home    = !fifo_empty && (head_entry.gcid == HOME_GCID);
      head_transit = !fifo_empty && (head_entry.gcid != HOME_GCID);
      pop          = (head_transit && !ring_transit) || (head_home && !ring_home);
   end

   always_comb begin
      dest_sel        = '0;
      dest_sel_valid  = 1'b0;
      cache_sel       = '0;
      cache_sel_valid = 1'b0;
      if (ring_transit) begin
         dest_sel       = ring_entry;
         dest_sel_valid = 1'b1;
      end else if (head_transit) begin
         dest_sel       = head_entry;
         dest_sel_valid = 1'b1;
      end
      if (ring_home) begin
         cache_sel       = ring_entry;
         cache_sel_valid = 1'b1;
      end else if (head_home) begin
         cache_sel       = head_entry;
         cache_sel_valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         o_dest_nb_force                 <= '0;
         o_dest_nb_parid                 <= '0;
         o_dest_nb_gcid                  <= '0;
         o_dest_nb_valid                 <= 1'b0;
         o_nb_force_to_force_cache       <= '0;
         o_nb_parid_to_force_cache       <= '0;
         o_nb_force_to_force_cache_valid <= 1'b0;
      end else begin
         o_dest_nb_valid                 <= dest_sel_valid;
         o_nb_force_to_force_cache_valid <= cache_sel_valid;
         if (dest_sel_valid) begin
            o_dest_nb_force <= dest_sel.f;
            o_dest_nb_parid <= dest_sel.parid;
            o_dest_nb_gcid  <= dest_sel.gcid;
         end
         if (cache_sel_valid) begin
            o_nb_force_to_force_cache <= cache_sel.f;
            o_nb_parid_to_force_cache <= cache_sel.parid;
         end
      end
   end

   assign o_buffer_empty = fifo_empty;

endmodule

// File: tb/tb_force_output_ring_node.sv
// Directed bench for force_output_ring_node with home cell (0,0,0).
module tb_force_output_ring_node;
   import MD_pkg::*;

   logic                         clk;
   logic                         rst;
   force_packet_t                nb_force;
   logic                         nb_force_valid;
   float_data_t                  source_force;
   logic [PARTICLE_ID_WIDTH-1:0] source_parid;
   logic [GCID_WIDTH-1:0]        source_gcid;
   logic                         source_valid;
   float_data_t                  dest_force;
   logic [PARTICLE_ID_WIDTH-1:0] dest_parid;
   logic [GCID_WIDTH-1:0]        dest_gcid;
   logic                         dest_valid;
   float_data_t                  cache_force;
   logic                         cache_valid;
   logic [PARTICLE_ID_WIDTH-1:0] cache_parid;
   logic                         buffer_empty;

   int checks   = 0;
   int failures = 0;

   force_output_ring_node #(
      .GCELL_X    (3'b000),
      .GCELL_Y    (3'b000),
      .GCELL_Z    (3'b000),
      .FIFO_DEPTH (16)
   ) dut (
      .clk                             (clk),
      .rst                             (rst),
      .i_nb_force                      (nb_force),
      .i_nb_force_valid                (nb_force_valid),
      .i_source_nb_force               (source_force),
      .i_source_nb_parid               (source_parid),
      .i_source_nb_gcid                (source_gcid),
      .i_source_nb_valid               (source_valid),
      .o_dest_nb_force                 (dest_force),
      .o_dest_nb_parid                 (dest_parid),
      .o_dest_nb_gcid                  (dest_gcid),
      .o_dest_nb_valid                 (dest_valid),
      .o_nb_force_to_force_cache       (cache_force),
      .o_nb_force_to_force_cache_valid (cache_valid),
      .o_nb_parid_to_force_cache       (cache_parid),
      .o_buffer_empty                  (buffer_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      nb_force       = '0;
      nb_force_valid = 1'b0;
      source_force   = '0;
      source_parid   = '0;
      source_gcid    = '0;
      source_valid   = 1'b0;
   endtask

   task automatic drive_local(input int p, input logic [5:0] cid);
      nb_force.f.x    = 32'(p);
      nb_force.f.y    = 32'(p);
      nb_force.f.z    = 32'(p);
      nb_force.parid  = 8'(p);
      nb_force.cid    = cid;
      nb_force_valid  = 1'b1;
   endtask

   task automatic drive_ring(input int p, input logic [8:0] gcid);
      source_force.x = 32'(p);
      source_force.y = 32'(p);
      source_force.z = 32'(p);
      source_parid   = 8'(p);
      source_gcid    = gcid;
      source_valid   = 1'b1;
   endtask

   int pids1 [7]   = '{1, 3, 4, 5, 6, 7, 8};
   int exp_t2 [7]  = '{0, 10, 50, 11, 12, 13, 0};

   initial begin
      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      check("rst_dest_valid", dest_valid, 0);
      check("rst_cache_valid", cache_valid, 0);
      check("rst_empty", buffer_empty, 1);
      check("rst_dest_parid", dest_parid, 0);
      check("rst_dest_gcid", dest_gcid, 0);
      check("rst_cache_parid", cache_parid, 0);
      check("rst_cache_force", cache_force.x, 0);
      rst = 1'b1;
      tick();

      // Local burst towards (1,1,1) with a home ring packet injected mid-burst.
      for (int i = 0; i <= 8; i++) begin
         clear_inputs();
         if (i < 7) drive_local(pids1[i], 6'b101010);
         if (i == 2) drive_ring(6, 9'd0);
         tick();
         check("t1_dest_valid", dest_valid, (i >= 1 && i <= 7));
         if (i >= 1 && i <= 7) begin
            check("t1_dest_parid", dest_parid, pids1[i-1]);
            check("t1_dest_gcid", dest_gcid, 9'b001001001);
            check("t1_dest_force", dest_force.z, pids1[i-1]);
         end
         check("t1_cache_valid", cache_valid, (i == 2));
         if (i == 2) begin
            check("t1_cache_parid", cache_parid, 6);
            check("t1_cache_force", cache_force.y, 6);
         end
         check("t1_empty", buffer_empty, (i >= 7));
      end

      // Transit ring packet preempts buffer injection for one cycle.
      for (int i = 0; i <= 6; i++) begin
         clear_inputs();
         if (i < 4) drive_local(10 + i, 6'b101010);
         if (i == 2) drive_ring(50, 9'b001001001);
         tick();
         check("t2_dest_valid", dest_valid, (i >= 1 && i <= 5));
         if (i >= 1 && i <= 5) begin
            check("t2_dest_parid", dest_parid, exp_t2[i]);
            check("t2_dest_force", dest_force.x, exp_t2[i]);
         end
         check("t2_cache_valid", cache_valid, 0);
         check("t2_empty", buffer_empty, (i >= 5));
      end

      // Home local packet collides with a home ring packet.
      for (int i = 0; i <= 2; i++) begin
         clear_inputs();
         if (i == 0) begin
            drive_local(20, 6'b010101);
            drive_ring(21, 9'd0);
         end
         tick();
         check("t3_cache_valid", cache_valid, (i <= 1));
         if (i == 0) check("t3_cache_parid_ring", cache_parid, 21);
         if (i == 1) begin
            check("t3_cache_parid_local", cache_parid, 20);
            check("t3_cache_force_local", cache_force.x, 20);
         end
         check("t3_dest_valid", dest_valid, 0);
         check("t3_empty", buffer_empty, (i >= 1));
      end

      // Offset wrap below zero and the 2'b11 code.
      for (int i = 0; i <= 3; i++) begin
         clear_inputs();
         if (i == 0) drive_local(40, 6'b000000);
         if (i == 1) drive_local(41, 6'b110001);
         tick();
         check("t4_dest_valid", dest_valid, (i == 1 || i == 2));
         if (i == 1) begin
            check("t4_gcid_wrap", dest_gcid, 9'b111111111);
            check("t4_parid_wrap", dest_parid, 40);
         end
         if (i == 2) begin
            check("t4_gcid_code11", dest_gcid, 9'b000111000);
            check("t4_parid_code11", dest_parid, 41);
         end
         check("t4_empty", buffer_empty, (i >= 2));
      end

      // Fill three entries behind continuous transit traffic, then reset.
      for (int i = 0; i <= 2; i++) begin
         clear_inputs();
         drive_local(30 + i, 6'b101010);
         drive_ring(60 + i, 9'b001001001);
         tick();
         check("t5_fwd_valid", dest_valid, 1);
         check("t5_fwd_parid", dest_parid, 60 + i);
         check("t5_empty", buffer_empty, 0);
      end
      clear_inputs();
      rst = 1'b0;
      tick();
      check("t5_rst_dest_valid", dest_valid, 0);
      check("t5_rst_cache_valid", cache_valid, 0);
      check("t5_rst_empty", buffer_empty, 1);
      check("t5_rst_dest_parid", dest_parid, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_post_dest_valid", dest_valid, 0);
         check("t5_post_cache_valid", cache_valid, 0);
         check("t5_post_empty", buffer_empty, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/force_output_ring_node.md
FORCE_OUTPUT_RING_NODE -- requirements
Module: force_output_ring_node

Interface
REQ-001 SHALL have parameters: GCELL_X, 3 bits, default 3'b000, home cell x; GCELL_Y, 3 bits, default 3'b000, home cell y; GCELL_Z, 3 bits, default 3'b000, home cell z; FIFO_DEPTH, default 16, local buffer entries (power of 2).
REQ-002 SHALL have ports (name  direction  width  meaning):
clk  in  1  single clock, all logic rising-edge;
rst  in  1  synchronous reset, active-low (asserted when 0);
i_nb_force  in  force_packet_t  PE neighbour force {f, parid, cid};
i_nb_force_valid  in  1  qualifies i_nb_force;
i_source_nb_force  in  float_data_t  force from previous ring node;
i_source_nb_parid  in  PARTICLE_ID_WIDTH  particle id from previous node;
i_source_nb_gcid  in  3*GLOBAL_CELL_ID_WIDTH  destination {z,y,x} from previous node;
i_source_nb_valid  in  1  qualifies ring input;
o_dest_nb_force  out  float_data_t  force to next node;
o_dest_nb_parid  out  PARTICLE_ID_WIDTH  particle id to next node;
o_dest_nb_gcid  out  3*GLOBAL_CELL_ID_WIDTH  destination {z,y,x} to next node;
o_dest_nb_valid  out  1  qualifies ring output;
o_nb_force_to_force_cache  out  float_data_t  force for home cache;
o_nb_force_to_force_cache_valid  out  1  qualifies cache output;
o_nb_parid_to_force_cache  out  PARTICLE_ID_WIDTH  particle id for home cache;
o_buffer_empty  out  1  local FIFO empty.

Function
REQ-003 SHALL map cid {cz,cy,cx} (2 bits each) to offset per axis: 2'b00 = -1, 2'b01 = 0, 2'b10 = +1, 2'b11 treated as 0; gcid axis = home axis + offset modulo 8; gcid packed {z,y,x}.
REQ-004 SHALL write every valid local packet, with computed gcid, into the FIFO on the clock edge it is presented.
REQ-005 SHALL classify ring input: gcid == {GCELL_Z,GCELL_Y,GCELL_X} is "home", otherwise "transit"; FIFO head classified the same way.
REQ-006 SHALL forward a transit ring input to o_dest_* on the next edge (1-cycle latency), unchanged.
REQ-007 SHALL deliver a home ring input to the force-cache outputs on the next edge (1-cycle latency); it is never forwarded.
REQ-008 SHALL pop a transit FIFO head into o_dest_* only in a cycle with no transit ring input (ring traffic has priority).
REQ-009 SHALL pop a home FIFO head to the force-cache outputs only in a cycle with no home ring input (ring traffic has priority).
REQ-010 SHALL pop at most one entry per cycle; head-of-line order preserved; minimum local-to-output latency 2 edges.
REQ-011 SHALL allow simultaneous FIFO write and pop; a write while full (and no pop) is discarded; upstream SHALL NOT exceed FIFO_DEPTH outstanding packets.
REQ-012 SHALL register all outputs; valids are 0 in any cycle with nothing selected; data outputs hold last value when invalid.
REQ-013 SHALL drive o_buffer_empty = 1 exactly when FIFO count is 0, updated same edge as count.
REQ-014 SHALL never stall or drop ring input (no ring backpressure).

Reset
REQ-015 SHALL on rst = 0 at an edge clear FIFO pointers and count, all valids to 0, all data outputs to 0, o_buffer_empty to 1; in-flight and buffered packets are lost, including mid-operation.

Structure
REQ-016 SHALL take from shared package MD_pkg: FLOAT_WIDTH = 32, float_data_t {x,y,z}, PARTICLE_ID_WIDTH, GLOBAL_CELL_ID_WIDTH = 3, NB_CID_WIDTH = 6, force_packet_t {f, parid, cid}.
REQ-017 SHALL implement the buffer as one sub-module, force_ring_fifo (synchronous, parameterised width and depth, show-ahead head).

Verification
REQ-018 Local burst: home 0,0,0; parids 1,3,4,5,6,7,8 with cid 6'b101010, f = parid, one per cycle -> o_dest_nb_valid for 7 consecutive cycles starting 2 edges after first input, gcid 9'b001001001, parids in order; cache valid never set.
REQ-019 Home ring input parid 6, gcid 0, during that burst -> cache output parid 6, force 6, 1 edge later; ring output sequence uninterrupted.
REQ-020 Transit ring input gcid 9'b001001001 while FIFO non-empty -> forwarded 1 edge later; FIFO injection stalls that cycle, resumes next; no loss or reorder.
REQ-021 Local cid 6'b010101 plus simultaneous home ring input -> ring packet to cache first, local packet next cycle; o_buffer_empty returns to 1 afterwards.
REQ-022 Reset asserted with 3 entries buffered -> next cycle all valids 0, o_buffer_empty 1; no stale output after release.
